cacheline_arbiter: RTL and testbench

- Shares the single physical-memory port (pmem_*) of mp3 between the instruction cache and the data cache.
- Each transfer is one full cacheline (read fill or dirty writeback).
- Sits between both caches and the pmem interface driven by the testbench memory model.
- Selects one requester, holds the grant until pmem_resp, routes the response back, and counts grants and contention for performance analysis.

---
 rtl/cacheline_arbiter.sv | 135 +++++++++++++
 tb/tb_cacheline_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// Arbitrates the single pmem port between icache and dcache, one cacheline
// per grant, with grant and contention counters for performance analysis.
module cacheline_arbiter #(
   parameter int LINE_WIDTH    = 256,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic [31:0]           i_grant_count,
   output logic [31:0]           d_grant_count,
   output logic [31:0]           contention_count
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D_READ,
      SERVE_D_WRITE
   } state_t;

   state_t                state, state_n;
   logic                  last_d, last_d_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_n;
   logic                  d_req;
   logic                  pick_d;
   logic                  serve_d;

   assign d_req        = d_pmem_read | d_pmem_write;
   assign serve_d      = (state == SERVE_D_READ) || (state == SERVE_D_WRITE);
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   // On a tie, round-robin hands the grant to whoever did not have it last
   always_comb begin
      pick_d = 1'b0;
      if (d_req && !i_pmem_read)
         pick_d = 1'b1;
      else if (d_req && i_pmem_read)
         pick_d = (DATA_PRIORITY != 0) ? 1'b1 : !last_d;
   end

   always_comb begin
      state_n     = state;
      last_d_n    = last_d;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_pmem_read || d_req) begin
               last_d_n = pick_d;
               wdata_n  = '0;
               if (pick_d) begin
                  addr_n = d_pmem_address;
                  if (d_pmem_write) begin
                     state_n = SERVE_D_WRITE;
                     wdata_n = d_pmem_wdata;
                  end else begin
                     state_n = SERVE_D_READ;
                  end
               end else begin
                  state_n = SERVE_I;
                  addr_n  = i_pmem_address;
               end
            end
         end
         SERVE_I: begin
            pmem_read   = 1'b1;
            i_pmem_resp = pmem_resp;
         end
         SERVE_D_READ: begin
            pmem_read   = 1'b1;
            d_pmem_resp = pmem_resp;
         end
         SERVE_D_WRITE: begin
            pmem_write  = 1'b1;
            d_pmem_resp = pmem_resp;
         end
         default: state_n = IDLE;
      endcase
      // Clearing the latches keeps the pmem bus at zero while idle
      if (state != IDLE && pmem_resp) begin
         state_n = IDLE;
         addr_n  = '0;
         wdata_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         last_d           <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= '0;
         i_grant_count    <= '0;
         d_grant_count    <= '0;
         contention_count <= '0;
      end else begin
         state   <= state_n;
         last_d  <= last_d_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         if (state == SERVE_I && pmem_resp)
            i_grant_count <= i_grant_count + 32'd1;
         if (serve_d && pmem_resp)
            d_grant_count <= d_grant_count + 32'd1;
         if ((state == SERVE_I && d_req) || (serve_d && i_pmem_read))
            contention_count <= contention_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: one instance per tie policy,
// sharing stimulus, with the idle instance held in reset.
module tb_cacheline_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst0, rst1;
   logic         i_req;
   logic [31:0]  i_addr;
   logic         d_read, d_write;
   logic [31:0]  d_addr;
   logic [255:0] d_wdata;
   logic [255:0] pm_rdata;
   logic         pm_resp;

   logic         p_read   [2];
   logic         p_write  [2];
   logic [31:0]  p_addr   [2];
   logic [255:0] p_wdata  [2];
   logic [255:0] p_irdata [2];
   logic [255:0] p_drdata [2];
   logic         p_iresp  [2];
   logic         p_dresp  [2];
   logic [31:0]  p_icnt   [2];
   logic [31:0]  p_dcnt   [2];
   logic [31:0]  p_ccnt   [2];

   cacheline_arbiter #(.DATA_PRIORITY(0)) u0 (
      .clk(clk), .rst(rst0),
      .i_pmem_read(i_req), .i_pmem_address(i_addr),
      .i_pmem_rdata(p_irdata[0]), .i_pmem_resp(p_iresp[0]),
      .d_pmem_read(d_read), .d_pmem_write(d_write),
      .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
      .d_pmem_rdata(p_drdata[0]), .d_pmem_resp(p_dresp[0]),
      .pmem_read(p_read[0]), .pmem_write(p_write[0]),
      .pmem_address(p_addr[0]), .pmem_wdata(p_wdata[0]),
      .pmem_rdata(pm_rdata), .pmem_resp(pm_resp),
      .i_grant_count(p_icnt[0]), .d_grant_count(p_dcnt[0]),
      .contention_count(p_ccnt[0])
   );

   cacheline_arbiter #(.DATA_PRIORITY(1)) u1 (
      .clk(clk), .rst(rst1),
      .i_pmem_read(i_req), .i_pmem_address(i_addr),
      .i_pmem_rdata(p_irdata[1]), .i_pmem_resp(p_iresp[1]),
      .d_pmem_read(d_read), .d_pmem_write(d_write),
      .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
      .d_pmem_rdata(p_drdata[1]), .d_pmem_resp(p_dresp[1]),
      .pmem_read(p_read[1]), .pmem_write(p_write[1]),
      .pmem_address(p_addr[1]), .pmem_wdata(p_wdata[1]),
      .pmem_rdata(pm_rdata), .pmem_resp(pm_resp),
      .i_grant_count(p_icnt[1]), .d_grant_count(p_dcnt[1]),
      .contention_count(p_ccnt[1])
   );

   bit           sel;
   logic         pm_read, pm_write, i_resp, d_resp;
   logic [31:0]  pm_addr, i_cnt, d_cnt, c_cnt;
   logic [255:0] pm_wdata, i_rdat, d_rdat;

   assign pm_read  = p_read[sel];
   assign pm_write = p_write[sel];
   assign pm_addr  = p_addr[sel];
   assign pm_wdata = p_wdata[sel];
   assign i_rdat   = p_irdata[sel];
   assign d_rdat   = p_drdata[sel];
   assign i_resp   = p_iresp[sel];
   assign d_resp   = p_dresp[sel];
   assign i_cnt    = p_icnt[sel];
   assign d_cnt    = p_dcnt[sel];
   assign c_cnt    = p_ccnt[sel];

   typedef struct {
      bit           d;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } exp_t;

   exp_t sbq[$];
   int   ncheck = 0;
   int   nerr = 0;
   int   exp_i = 0, exp_d = 0, exp_c = 0;
   int   wait_cyc;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      ncheck++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input bit d, input bit wr, input logic [31:0] a,
                       input logic [255:0] wd);
      exp_t e;
      e.d = d;
      e.wr = wr;
      e.addr = a;
      e.wdata = wd;
      sbq.push_back(e);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_icnt"}, i_cnt, exp_i);
      check({tag, "_dcnt"}, d_cnt, exp_d);
      check({tag, "_ccnt"}, c_cnt, exp_c);
   endtask

   // Waits for a grant, serves it after lat cycles, compares against the
   // scoreboard head; keep leaves the owner requesting again afterwards.
   task automatic do_xfer(input int lat, input logic [255:0] rd,
                          input bit keep);
      exp_t e;
      bit   seen;
      int   n;
      seen = 0;
      wait_cyc = 0;
      while (!seen && wait_cyc < 20) begin
         @(negedge clk); #1;
         if (pm_read || pm_write) seen = 1;
         else wait_cyc++;
      end
      check("grant_seen", seen, 1);
      if (!seen) return;
      check("sb_empty", sbq.size() == 0, 0);
      if (sbq.size() == 0) return;
      e = sbq.pop_front();
      n = 0;
      forever begin
         if (n == lat) begin
            pm_resp = 1'b1;
            pm_rdata = rd;
            #1;
         end
         check("pm_read", pm_read, !e.wr);
         check("pm_write", pm_write, e.wr);
         check("pm_addr", pm_addr, e.addr);
         check("pm_wdata", pm_wdata, e.wr ? e.wdata : 256'd0);
         check("i_resp", i_resp, !e.d && n == lat);
         check("d_resp", d_resp, e.d && n == lat);
         if (n == lat)
            check("rdata", e.d ? d_rdat : i_rdat, rd);
         if (e.d ? i_req : (d_read | d_write)) exp_c++;
         if (n == 1) begin
            if (e.d) begin
               d_addr = d_addr ^ 32'h3000;
               d_wdata = ~d_wdata;
            end else begin
               i_addr = i_addr ^ 32'h3000;
            end
         end
         if (n == lat) break;
         n++;
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      pm_resp = 1'b0;
      if (e.d) exp_d++;
      else exp_i++;
      if (!keep) begin
         if (e.d) begin
            d_read = 1'b0;
            d_write = 1'b0;
         end else begin
            i_req = 1'b0;
         end
      end
      @(negedge clk); #1;
      check("idle_gap", pm_read | pm_write, 0);
      check_counts("post");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] a5, dead;
      a5 = {8{32'hA5A5A5A5}};
      dead = {8{32'hDEADBEEF}};
      sel = 1'b0;
      rst0 = 1'b1;
      rst1 = 1'b1;
      i_req = 0; i_addr = 0;
      d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
      pm_rdata = 0; pm_resp = 0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_read", pm_read, 0);
      check("rst_write", pm_write, 0);
      check("rst_addr", pm_addr, 0);
      check("rst_wdata", pm_wdata, 0);
      check("rst_iresp", i_resp, 0);
      check("rst_dresp", d_resp, 0);
      check_counts("rst");
      rst0 = 1'b0;

      // icache alone
      i_req = 1; i_addr = 32'h60;
      push(0, 0, 32'h60, 0);
      do_xfer(5, a5, 0);
      check("i_latency", wait_cyc, 0);

      // tie: D first, then D re-requests and the second tie goes to I
      i_req = 1; i_addr = 32'h80;
      d_read = 1; d_addr = 32'h100;
      push(1, 0, 32'h100, 0);
      do_xfer(3, {8{32'h11112222}}, 1);
      d_addr = 32'h140;
      push(0, 0, 32'h80, 0);
      push(1, 0, 32'h140, 0);
      do_xfer(4, {8{32'h33334444}}, 0);
      do_xfer(2, {8{32'h55556666}}, 0);

      // writeback with the address moving mid-transfer
      d_write = 1; d_addr = 32'h1000; d_wdata = dead;
      push(1, 1, 32'h1000, dead);
      do_xfer(4, {8{32'h77778888}}, 0);

      // read and write together: write wins
      d_read = 1; d_write = 1; d_addr = 32'h3000;
      d_wdata = {8{32'h0BADF00D}};
      push(1, 1, 32'h3000, {8{32'h0BADF00D}});
      do_xfer(2, {8{32'h9999AAAA}}, 0);

      // stray resp while idle
      pm_resp = 1; pm_rdata = a5;
      #1;
      check("stray_iresp", i_resp, 0);
      check("stray_dresp", d_resp, 0);
      @(posedge clk); #1;
      pm_resp = 0;
      @(negedge clk); #1;
      check_counts("stray");

      // reset in the middle of an icache fill
      i_req = 1; i_addr = 32'h200;
      @(negedge clk); #1;
      check("pre_rst_read", pm_read, 1);
      @(negedge clk); #1;
      rst0 = 1; i_req = 0;
      @(negedge clk); #1;
      rst0 = 0;
      exp_i = 0; exp_d = 0; exp_c = 0;
      check("mid_rst_read", pm_read, 0);
      check("mid_rst_addr", pm_addr, 0);
      check_counts("mid_rst");
      pm_resp = 1;
      #1;
      check("late_iresp", i_resp, 0);
      check("late_dresp", d_resp, 0);
      @(posedge clk); #1;
      pm_resp = 0;
      @(negedge clk); #1;
      check("late_read", pm_read, 0);
      check_counts("late");

      // data-priority instance: three ties all go to D
      rst0 = 1;
      rst1 = 0;
      sel = 1'b1;
      check_counts("dp_rst");
      i_req = 1; i_addr = 32'h400;
      d_read = 1; d_addr = 32'h500;
      push(1, 0, 32'h500, 0);
      do_xfer(2, {8{32'hC0C0C0C0}}, 1);
      d_addr = 32'h540;
      push(1, 0, 32'h540, 0);
      do_xfer(2, {8{32'hC1C1C1C1}}, 1);
      d_addr = 32'h580;
      push(1, 0, 32'h580, 0);
      push(0, 0, 32'h400, 0);
      do_xfer(2, {8{32'hC2C2C2C2}}, 0);
      do_xfer(3, {8{32'hC3C3C3C3}}, 0);

      $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
      $finish;
   end

endmodule
